memory_ctrl: RTL
================

# memory_ctrl

Parametrised, handshaked data/instruction RAM for the CPU core. It replaces a fixed-latency, word-only store with byte, halfword and word accesses, optional sign extension, and alignment and range checking. It also has a configurable wait-state count and a hardware fill sequence that writes a NOP pattern into every word after reset. It sits between the core's load/store/fetch logic and the byte array, and is the only path into memory.

## Interface
- NUM_OF_BYTES, 1024, memory size in bytes; must be a multiple of 4, at least 8.
- WAIT_STATES, 1, extra cycles between accept and response for legal accesses; range 0..15.
- INIT_WORD, 32'hE1A00000, value written to every word during the fill sequence (MOV R0, R0).
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; restarts the fill sequence.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (error).
- req_signed  in  1  loads only: sign-extend byte/halfword results.
- address  in  32  byte address.
- write_data  in  32  store data, taken from the low bytes (byte = [7:0], halfword = [15:0]).
- resp_valid  out  1  one-cycle response pulse.
- resp_error  out  1  qualified by resp_valid: access rejected, memory unchanged.
- read_data  out  32  load result, qualified by resp_valid.
- init_busy  out  1  fill sequence in progress.

## Operation
- Byte order is little-endian: byte at address goes to [7:0], address+1 to [15:8], and so on.
- States are INIT, IDLE, WAIT and RESP.
- INIT:
  - Entered on every cycle with reset high.
  - Writes INIT_WORD to one word per cycle, starting at word 0.
  - Stays for NUM_OF_BYTES/4 cycles after reset deasserts, then goes to IDLE.
  - init_busy=1 and req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - A request is accepted on an edge with req_valid=1.
  - address, size, write, signed and data are captured at accept; later changes on the inputs are ignored.
- Error check at accept. The request is an error if any of the following holds:
  - req_size=11.
  - Halfword with address[0]=1.
  - Word with address[1:0]≠0.
  - address + nbytes > NUM_OF_BYTES, computed in 33 bits so addresses near 32'hFFFFFFFF do not wrap.
- On error: go directly to RESP; no write, no wait states.
- Legal request: go to WAIT for WAIT_STATES cycles, then RESP. If WAIT_STATES=0, go directly to RESP.
- Store commit:
  - Store bytes are written on the edge that enters RESP.
  - Only the addressed bytes change.
- RESP:
  - Lasts exactly one cycle with resp_valid=1 and req_ready=0, then returns to IDLE.
  - There is no response back-pressure.
- Load result:
  - Byte/halfword results are zero-extended, or sign-extended when req_signed=1.
  - req_signed is ignored for words and stores.
- Stores and errors drive read_data=0 in RESP.
- read_data and resp_error hold their values after RESP until the next response.
- Reset mid-operation: the transaction is aborted with no response. A store not yet committed is dropped. The whole array is refilled.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_error=0, read_data=0, init_busy=1.
- First accept is possible NUM_OF_BYTES/4 cycles after the first cycle with reset low.
- Latency is measured from accept cycle T:
  - Legal access: resp_valid in cycle T+1+WAIT_STATES.
  - Error: resp_valid in cycle T+1.
- Next accept is possible in the cycle after RESP. Peak throughput is one access per WAIT_STATES+2 cycles.
- A load issued immediately after a store to the same bytes returns the new data.

## Test plan
- Reset, then count cycles with NUM_OF_BYTES=64 → init_busy is high for 16 cycles after reset falls. Word loads at addresses 0 and 60 return 32'hE1A00000 with resp_error=0.
- WAIT_STATES=2: store word 32'h11223344 at address 8, then load byte at 9 (signed=0), halfword at 10 (signed=1), word at 8:
  - Byte at 9 returns 32'h00000033.
  - Halfword at 10 returns 32'h00001122.
  - Word at 8 returns 32'h11223344.
  - Each resp_valid falls in cycle T+3.
- Store byte 8'h80 at address 12, then load byte at 12 signed → 32'hFFFFFF80. Loading the word at 12 returns 32'hE1A00080, showing only one byte was written.
- Send each of these errors with WAIT_STATES=2:
  - Word at 2.
  - Halfword at 5.
  - req_size=11.
  - Word at NUM_OF_BYTES-2.
  - Word at 32'hFFFFFFFC.
  - Each gives resp_error=1 at T+1 and read_data=0. A following load of the target word shows it unchanged.
- Assert reset during WAIT of a store to address 16 → no resp_valid is produced, the fill sequence reruns, and the word at 16 reads INIT_WORD.
- Hold req_valid high continuously with WAIT_STATES=0 → accepts occur every 2 cycles and req_ready is low in RESP.

Source files
------------

// File: rtl/memory_ctrl.sv
// memory_ctrl: handshaked byte-addressable RAM with byte/halfword/word
// accesses, optional sign extension, alignment and range checking, a
// configurable number of wait states and a post-reset NOP fill sequence.
// Little-endian: the byte at the access address lands in bits [7:0].
module memory_ctrl #(
  parameter int          NUM_OF_BYTES = 1024,
  parameter int          WAIT_STATES  = 1,
  parameter logic [31:0] INIT_WORD    = 32'hE1A00000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  output logic        o_resp_valid,
  output logic        o_resp_error,
  output logic [31:0] o_read_data,
  output logic        o_init_busy
);

  localparam int NUM_WORDS = NUM_OF_BYTES / 4;
  localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int ADDR_W    = WIDX_W + 2;

  localparam logic [WIDX_W-1:0] LAST_WIDX = WIDX_W'(NUM_WORDS - 1);
  localparam logic [32:0]       MEM_LIMIT = 33'(NUM_OF_BYTES);
  localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] f_nbytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Reserved size, misalignment, or any byte past the end of the array.
  // The end address is formed in 33 bits so high addresses cannot wrap.
  function automatic logic f_access_error(input logic [1:0]  size,
                                          input logic [31:0] addr);
    logic [32:0] end_addr;
    logic        bad_shape;
    end_addr = {1'b0, addr} + {30'd0, f_nbytes(size)};
    case (size)
      2'b00:   bad_shape = 1'b0;
      2'b01:   bad_shape = addr[0];
      2'b10:   bad_shape = (addr[1:0] != 2'b00);
      default: bad_shape = 1'b1;
    endcase
    return bad_shape || (end_addr > MEM_LIMIT);
  endfunction

  // Byte lanes of the containing word touched by an access.
  function automatic logic [3:0] f_byte_en(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Zero- or sign-extend a right-aligned byte/halfword load result.
  function automatic logic [31:0] f_extend(input logic [31:0] data,
                                           input logic [1:0]  size,
                                           input logic        sign);
    logic [31:0] res;
    case (size)
      2'b00:   res = sign ? {{24{data[7]}}, data[7:0]}  : {24'h000000, data[7:0]};
      2'b01:   res = sign ? {{16{data[15]}}, data[15:0]} : {16'h0000, data[15:0]};
      default: res = data;
    endcase
    return res;
  endfunction

  // Storage and state
  logic [31:0]       r_mem [0:NUM_WORDS-1];
  state_t            r_state;
  logic [3:0]        r_wait_cnt;
  logic [WIDX_W-1:0] r_fill_cnt;

  // Captured request
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_write;
  logic              r_signed;
  logic [31:0]       r_wdata;
  logic              r_err;

  // Registered outputs
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_error;
  logic [31:0]       r_read_data;
  logic              r_init_busy;

  // Combinational signals
  state_t            w_state_nxt;
  logic [3:0]        w_wait_nxt;
  logic              w_accept;
  logic              w_in_err;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [1:0]        w_cur_size;
  logic              w_cur_write;
  logic              w_cur_signed;
  logic [31:0]       w_cur_wdata;
  logic              w_cur_err;
  logic              w_enter_resp;
  logic              w_commit;
  logic [WIDX_W-1:0] w_widx;
  logic [31:0]       w_rword;
  logic [31:0]       w_shifted;
  logic [31:0]       w_resp_data;
  logic [3:0]        w_be;
  logic [31:0]       w_lane_data;

  assign w_accept = (r_state == ST_IDLE) && i_req_valid;
  assign w_in_err = f_access_error(i_req_size, i_address);

  // Select the live request: straight from the inputs at accept, else the captured copy.
  always_comb begin
    w_cur_addr   = r_addr;
    w_cur_size   = r_size;
    w_cur_write  = r_write;
    w_cur_signed = r_signed;
    w_cur_wdata  = r_wdata;
    w_cur_err    = r_err;
    if (r_state == ST_IDLE) begin
      w_cur_addr   = i_address[ADDR_W-1:0];
      w_cur_size   = i_req_size;
      w_cur_write  = i_req_write;
      w_cur_signed = i_req_signed;
      w_cur_wdata  = i_write_data;
      w_cur_err    = w_in_err;
    end else begin
      w_cur_err    = r_err;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_fill_cnt == LAST_WIDX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (i_req_valid) begin
          if (w_in_err || (WAIT_STATES == 0)) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_wait_nxt  = WAIT_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_WAIT;
          w_wait_nxt  = r_wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // Data path for the response: read the addressed word, align, extend; store lanes.
  always_comb begin
    w_enter_resp = (w_state_nxt == ST_RESP) && !i_reset;
    w_commit     = w_enter_resp && w_cur_write && !w_cur_err;
    if (w_cur_err) begin
      w_widx = {WIDX_W{1'b0}};
    end else begin
      w_widx = w_cur_addr[ADDR_W-1:2];
    end
    w_rword     = r_mem[w_widx];
    w_shifted   = w_rword >> {w_cur_addr[1:0], 3'b000};
    w_be        = f_byte_en(w_cur_size, w_cur_addr[1:0]);
    w_lane_data = w_cur_wdata << {w_cur_addr[1:0], 3'b000};
    if (w_cur_err || w_cur_write) begin
      w_resp_data = 32'h0000_0000;
    end else begin
      w_resp_data = f_extend(w_shifted, w_cur_size, w_cur_signed);
    end
  end

  // Array writes: NOP fill one word per cycle during INIT, byte-lane store commit on entry to RESP.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_fill_cnt] <= INIT_WORD;
    end else if (w_commit) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_widx][8*k +: 8] <= w_lane_data[8*k +: 8];
        end
      end
    end
  end

  // State register and wait-state counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_INIT;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Fill-sequence word counter, held at word 0 while reset is high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fill_cnt <= {WIDX_W{1'b0}};
    end else if (r_state == ST_INIT) begin
      r_fill_cnt <= r_fill_cnt + WIDX_W'(1);
    end else begin
      r_fill_cnt <= {WIDX_W{1'b0}};
    end
  end

  // Capture the request at accept so later input changes have no effect.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr   <= {ADDR_W{1'b0}};
      r_size   <= 2'b00;
      r_write  <= 1'b0;
      r_signed <= 1'b0;
      r_wdata  <= 32'h0000_0000;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= i_address[ADDR_W-1:0];
      r_size   <= i_req_size;
      r_write  <= i_req_write;
      r_signed <= i_req_signed;
      r_wdata  <= i_write_data;
      r_err    <= w_in_err;
    end else begin
      r_addr   <= r_addr;
      r_size   <= r_size;
      r_write  <= r_write;
      r_signed <= r_signed;
      r_wdata  <= r_wdata;
      r_err    <= r_err;
    end
  end

  // Registered handshake/status outputs; response data and error hold until the next response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_read_data  <= 32'h0000_0000;
      r_init_busy  <= 1'b1;
    end else begin
      r_req_ready  <= (w_state_nxt == ST_IDLE);
      r_resp_valid <= (w_state_nxt == ST_RESP);
      r_init_busy  <= (w_state_nxt == ST_INIT);
      if (w_enter_resp) begin
        r_resp_error <= w_cur_err;
        r_read_data  <= w_resp_data;
      end else begin
        r_resp_error <= r_resp_error;
        r_read_data  <= r_read_data;
      end
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_error = r_resp_error;
  assign o_read_data  = r_read_data;
  assign o_init_busy  = r_init_busy;

endmodule
